// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode definitions: group geometry, slot-to-bit mapping and the
// {pc, inst} entry carried through the instruction queue.
package inst_queue_pkg;

    localparam int INST_W      = 32;
    localparam int PC_W        = 32;
    localparam int GROUP_W     = 128;
    localparam int FETCH_WIDTH = 4;

    // Slot i lives in bits [127-32i : 96-32i] of the group.
    function automatic int slot_lsb(input int slot);
        return GROUP_W - INST_W * (slot + 1);
    endfunction

    // Slot i is flagged by valid bit 3-i.
    function automatic int slot_valid_bit(input int slot);
        return FETCH_WIDTH - 1 - slot;
    endfunction

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

endpackage

// File: rtl/inst_compact.sv
// Packs the valid slots of a fetch group, in program order, into up to four
// {pc, inst} items plus their count. Purely combinational.
module inst_compact
    import inst_queue_pkg::*;
(
    input  logic [GROUP_W-1:0]     group,
    input  logic [FETCH_WIDTH-1:0] mask,
    input  logic [PC_W-1:0]        group_pc,
    output entry_t [FETCH_WIDTH-1:0] items,
    output logic [2:0]             n_items
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        items   = '0;
        n_items = '0;
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            if (mask[slot_valid_bit(s)]) begin
                items[n_items[1:0]].pc   = group_pc + PC_W'(4 * s);
                items[n_items[1:0]].inst = group[slot_lsb(s) +: INST_W];
                n_items                  = n_items + 3'd1;
            end
        end
    end

endmodule

// File: rtl/inst_queue.sv
// Decoupling queue between the 4-wide fetch stage and decode: compacts and
// stores fetch groups in a circular buffer, offers two in-order instructions.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DEQ_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [PC_W-1:0]       group_pc,
    input  logic [GROUP_W-1:0]    inst_group,
    input  logic [FETCH_WIDTH-1:0] inst_group_valid,
    input  logic                  pre_valid,
    output logic                  out_ready,
    output logic [DEQ_W*INST_W-1:0] deq_inst,
    output logic [DEQ_W*PC_W-1:0] deq_pc,
    output logic [DEQ_W-1:0]      deq_valid,
    input  logic                  next_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] ACCEPT_MAX = (PTR_W + 1)'(DEPTH - FETCH_WIDTH);

    entry_t                   mem_q [DEPTH];
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [PTR_W:0]           count_q, count_d;
    entry_t [FETCH_WIDTH-1:0] items;
    logic [2:0]               n_items;
    logic                     enq_fire;
    logic [PTR_W:0]           n_deq;

    inst_compact u_compact (
        .group    (inst_group),
        .mask     (inst_group_valid),
        .group_pc (group_pc),
        .items    (items),
        .n_items  (n_items)
    );

    // Acceptance looks only at registered occupancy, never at this cycle's dequeue.
    assign out_ready = (count_q <= ACCEPT_MAX);
    assign enq_fire  = pre_valid && out_ready && !flush;

    always_comb begin
        deq_valid = '0;
        for (int k = 0; k < DEQ_W; k++) begin
            deq_valid[k]                = (count_q > (PTR_W + 1)'(k));
            deq_inst[k*INST_W +: INST_W] = mem_q[head_q + PTR_W'(k)].inst;
            deq_pc[k*PC_W +: PC_W]       = mem_q[head_q + PTR_W'(k)].pc;
        end
    end

    always_comb begin
        n_deq = '0;
        if (next_ready) begin
            for (int k = 0; k < DEQ_W; k++) begin
                n_deq = n_deq + (PTR_W + 1)'(deq_valid[k]);
            end
        end

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(n_deq);
            count_d = count_q - n_deq;
            if (enq_fire) begin
                tail_d  = tail_q + PTR_W'(n_items);
                count_d = count_d + (PTR_W + 1)'(n_items);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is deliberately unreset; count gates every read of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq_fire && (3'(i) < n_items)) begin
                mem_q[tail_q + PTR_W'(i)] <= items[i];
            end
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue with a scoreboard of expected
// {pc, inst} entries in program order.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [31:0]  group_pc;
    logic [127:0] inst_group;
    logic [3:0]   inst_group_valid;
    logic         pre_valid;
    logic         out_ready;
    logic [63:0]  deq_inst;
    logic [63:0]  deq_pc;
    logic [1:0]   deq_valid;
    logic         next_ready;

    int errors = 0;
    int checks = 0;
    entry_t sb[$];

    inst_queue #(.DEPTH(DEPTH), .DEQ_W(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .group_pc         (group_pc),
        .inst_group       (inst_group),
        .inst_group_valid (inst_group_valid),
        .pre_valid        (pre_valid),
        .out_ready        (out_ready),
        .deq_inst         (deq_inst),
        .deq_pc           (deq_pc),
        .deq_valid        (deq_valid),
        .next_ready       (next_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] rnd_group();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Checks outputs for the current state, drives one cycle of inputs, updates the model.
    task automatic step(input logic pv, input logic [31:0] pc, input logic [127:0] grp,
                        input logic [3:0] mask, input logic nr, input logic fl);
        int     sz;
        int     n;
        logic   exp_rdy;
        entry_t e;
        sz      = sb.size();
        exp_rdy = (DEPTH - sz) >= 4;
        chk("out_ready", 64'(out_ready), 64'(exp_rdy));
        chk("deq_valid", 64'(deq_valid), 64'({sz >= 2, sz >= 1}));
        if (sz >= 1) begin
            chk("deq_inst0", 64'(deq_inst[31:0]), 64'(sb[0].inst));
            chk("deq_pc0",   64'(deq_pc[31:0]),   64'(sb[0].pc));
        end
        if (sz >= 2) begin
            chk("deq_inst1", 64'(deq_inst[63:32]), 64'(sb[1].inst));
            chk("deq_pc1",   64'(deq_pc[63:32]),   64'(sb[1].pc));
        end
        pre_valid        = pv;
        group_pc         = pc;
        inst_group       = grp;
        inst_group_valid = mask;
        next_ready       = nr;
        flush            = fl;
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            n = nr ? ((sz >= 2) ? 2 : sz) : 0;
            repeat (n) void'(sb.pop_front());
            if (pv && exp_rdy) begin
                for (int s = 0; s < 4; s++) begin
                    if (mask[3-s]) begin
                        e.pc   = pc + 32'(4 * s);
                        e.inst = grp[127-32*s -: 32];
                        sb.push_back(e);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic nr);
        step(1'b0, 32'h0, 128'h0, 4'h0, nr, 1'b0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; pre_valid = 1'b0; next_ready = 1'b0;
        group_pc = '0; inst_group = '0; inst_group_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_deq_valid", 64'(deq_valid), 64'h0);
        chk("reset_out_ready", 64'(out_ready), 64'h1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Reset and basic order
        step(1'b1, 32'h1C00_0000, mk(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004),
             4'hF, 1'b0, 1'b0);
        chk("basic_first_pc", 64'(deq_pc[31:0]), 64'h1C00_0000);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Compaction of slots {1,3}
        step(1'b1, 32'h100, mk(32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003),
             4'b0101, 1'b0, 1'b0);
        chk("compact_pc1", 64'(deq_pc[63:32]), 64'h10C);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Full: four full groups reach count 16
        for (int g = 0; g < 4; g++) step(1'b1, 32'h2000 + 32'(16 * g), rnd_group(), 4'hF, 1'b0, 1'b0);
        step(1'b1, 32'h3000, rnd_group(), 4'hF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 128'h0, 4'h0, 1'b0, 1'b1);
        // Count 13 refuses a push; draining 2 reopens the queue
        for (int g = 0; g < 3; g++) step(1'b1, 32'h4000 + 32'(16 * g), rnd_group(), 4'hF, 1'b0, 1'b0);
        step(1'b1, 32'h4030, rnd_group(), 4'b0010, 1'b0, 1'b0);
        step(1'b1, 32'h5000, rnd_group(), 4'b1000, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        step(1'b0, 32'h0, 128'h0, 4'h0, 1'b0, 1'b1);

        // Wrap: move head/tail to 14 then write across the end
        for (int g = 0; g < 3; g++) step(1'b1, 32'h6000 + 32'(16 * g), rnd_group(), 4'hF, 1'b0, 1'b0);
        repeat (6) idle(1'b1);
        step(1'b1, 32'h7000, rnd_group(), 4'b1100, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b1, 32'h8000, rnd_group(), 4'hF, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Flush at count 7 with a simultaneous push and dequeue
        step(1'b1, 32'h9000, rnd_group(), 4'hF, 1'b0, 1'b0);
        step(1'b1, 32'h9010, rnd_group(), 4'b1110, 1'b0, 1'b0);
        step(1'b1, 32'h9020, rnd_group(), 4'hF, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // Asynchronous reset off a clock edge
        step(1'b1, 32'hA000, rnd_group(), 4'hF, 1'b0, 1'b0);
        step(1'b1, 32'hA010, rnd_group(), 4'hF, 1'b1, 1'b0);
        pre_valid = 1'b0; next_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_deq_valid", 64'(deq_valid), 64'h0);
        chk("async_out_ready", 64'(out_ready), 64'h1);
        sb.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        idle(1'b0);
        step(1'b1, 32'hB000, rnd_group(), 4'b1001, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
